ecg_peak_threshold: RTL and testbench
=====================================

# ecg_peak_threshold

Parametrised adaptive-threshold generator for the ECG QRS detection path. It takes the filtered, signed ECG sample stream and computes a magnitude running maximum over fixed-length sample windows. It keeps the last `NWIN` window maxima in a ring and publishes a threshold equal to their average, scaled down by a power of two. Beat-decision logic downstream consumes `threshold` and the per-sample `peak_flag`.

## Interface
- `DW`, 32: sample and threshold width in bits, two's complement input.
- `WIN_LEN`, 256: accepted samples per window, ≥2.
- `NWIN`, 4: window maxima averaged; power of two, ≥1.
- `THR_SHIFT`, 1: the averaged maximum is right-shifted by this amount to form the threshold; 0..DW-2.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input DW: signed filtered ECG sample.
- `clear` input 1: synchronous restart of the current window.
- `threshold` output DW: current threshold, unsigned, MSB always 0.
- `thr_valid` output 1: one-cycle pulse when `threshold` updates.
- `cur_max` output DW: running maximum of the current window.
- `peak_flag` output 1: registered; the previous accepted sample exceeded `threshold`.
- `primed` output 1: `NWIN` windows have completed since reset.

## Operation
- Magnitude: `mag = |in_data|`. The most negative value saturates to 2^(DW-1)-1, so `mag` MSB is always 0.
- Sample accepted ⇔ `in_valid & ~clear`. Only accepted samples advance the window counter `wcnt` (0..WIN_LEN-1).
- Running max:
  - On an accepted sample with `wcnt==0`, `cur_max <= mag`.
  - Otherwise `cur_max <= max(cur_max, mag)`; ties leave it unchanged.
- Window end: on an accepted sample with `wcnt==WIN_LEN-1`:
  - `win_max = max(cur_max, mag)` is captured.
  - `wcnt` wraps to 0.
- History:
  - Ring of `NWIN` entries, each DW bits, all zero after reset.
  - Running sum `sum` has width DW+log2(NWIN) and never overflows.
  - On push: `sum <= sum + win_max - ring[wptr]`, `ring[wptr] <= win_max`, and `wptr` increments mod NWIN.
- Threshold: `threshold <= (sum >> log2(NWIN)) >> THR_SHIFT`, computed from the updated sum.
- State machine with two states:
  - FILL (after reset): a window counter counts pushes. On the NWIN-th push, go to RUN and set `primed`.
  - RUN: steady state. Only reset leaves RUN.
  - The threshold updates in both states. In FILL it averages over zeros for the unfilled slots.
- `peak_flag`:
  - Registered one cycle after each accepted sample as `primed & (mag > threshold)`.
  - Uses the `threshold` value present in the accept cycle.
  - `peak_flag` is 0 in any cycle that follows a non-accepted cycle.
- `clear`:
  - Sets `wcnt<=0` and `cur_max<=0`. Any sample presented in the same cycle is dropped.
  - Ring, sum, threshold, state and `primed` are preserved.
  - A push already in flight (see Timing) still completes.
- `rst_n=0`:
  - Zeroes everything: all outputs, ring, sum, `wptr` and `wcnt`; state returns to FILL.
  - Takes priority over all other inputs, including mid-window and mid-push.

## Timing
- Cycle N: the last sample of a window is accepted, and `win_max` is registered.
- Cycle N+1: ring and sum are updated.
- Cycle N+2: `threshold` is updated and `thr_valid=1` for exactly this cycle. `primed` rises in the same cycle on the NWIN-th window.
- The first sample of the next window may be accepted at N+1 with no bubble. It starts the new `cur_max` and is not part of the pushed maximum.
- The minimum window spacing is WIN_LEN ≥ 2 cycles, so pushes never overlap. No back-pressure is needed; samples are accepted at up to one per cycle.
- `cur_max` is registered and reflects samples accepted up to the previous cycle.
- `peak_flag` latency is 1 cycle after the accept.

## Test plan
Unless stated, the bench uses DW=16, WIN_LEN=4, NWIN=2, THR_SHIFT=1.

- **Reset:** hold `rst_n=0` for 3 cycles with random inputs.
  - All outputs must be 0 throughout.
  - After release, `threshold` stays 0 until the first `thr_valid`.
- **Basic windows:**
  - Samples 3, -10, 7, 2 → `thr_valid` 2 cycles after the 4th sample, with `threshold=2` ((10+0)/2>>1) and `primed=0`.
  - Next window 5, 20, -1, 0 → `threshold=7` ((10+20)/2>>1) and `primed=1`.
  - Third window with max 4 → `threshold=6` ((20+4)/2>>1).
- **Saturation:** a window containing -32768 gives `cur_max=32767` and a window maximum of 32767. Check that no wrap occurs in `sum` with both ring entries at 32767: `threshold=16383`.
- **Gaps and clear:**
  - Samples interleaved with `in_valid=0` cycles → identical results to the dense stream.
  - `clear` after 2 accepted samples → the window restarts. The next 4 accepted samples form the window, and the threshold is unchanged until that window ends.
  - `clear` together with `in_valid` → that sample is ignored.
- **Peak flag:**
  - After priming with `threshold=7`: sample 8 → `peak_flag=1` the next cycle. Samples 7 and -7 → `peak_flag=0`. Sample -9 → `peak_flag=1`.
  - Before priming → `peak_flag=0` always.
- **Reset mid-push:** assert `rst_n=0` in cycle N+1 of a push → `threshold`, `thr_valid` and `primed` are 0 afterwards. The next full window behaves as the first window after reset.

Source files
------------

// File: rtl/ecg_peak_threshold_if.sv
// Sample-stream and threshold bundle for the ECG adaptive-threshold block.
// Handshake: in_valid qualifies in_data in the same cycle. There is no ready
// and no back-pressure. A sample is taken exactly when in_valid is high and
// clear is low. thr_valid is a one-cycle pulse marking a new threshold value.
interface ecg_peak_threshold_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          clear;
    logic [DW-1:0] threshold;
    logic          thr_valid;
    logic [DW-1:0] cur_max;
    logic          peak_flag;
    logic          primed;
    logic          fsm_state;   // debug view of the FILL/RUN state (0 = FILL)

    modport master (
        output in_valid, in_data, clear,
        input  threshold, thr_valid, cur_max, peak_flag, primed, fsm_state
    );

    modport slave (
        input  in_valid, in_data, clear,
        output threshold, thr_valid, cur_max, peak_flag, primed, fsm_state
    );
endinterface

// File: rtl/ecg_peak_threshold.sv
// Adaptive QRS threshold.
// Tracks the magnitude maximum of each WIN_LEN-sample window and keeps the
// last NWIN maxima in a ring. The threshold is the ring average shifted right
// by THR_SHIFT. Pipeline: the window-end edge registers win_max, the next edge
// updates the ring, the sum and the threshold, and thr_valid pulses while the
// new threshold is first visible.
module ecg_peak_threshold #(
    parameter int DW        = 32,
    parameter int WIN_LEN   = 256,
    parameter int NWIN      = 4,
    parameter int THR_SHIFT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ecg_peak_threshold_if.slave bus
);
    localparam int LW = $clog2(NWIN);
    localparam int PW = (LW > 0) ? LW : 1;
    localparam int SW = DW + LW;
    localparam int CW = $clog2(WIN_LEN);
    localparam int FW = $clog2(NWIN + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [DW-1:0] MAG_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] mag;
    logic          accept;
    logic          win_last;

    logic [CW-1:0] wcnt_q;
    logic [DW-1:0] cur_max_q;
    logic [DW-1:0] win_max_q;
    logic          push_q;

    logic [DW-1:0] ring_q [NWIN];
    logic [SW-1:0] sum_q;
    logic [PW-1:0] wptr_q;
    logic [FW-1:0] fill_q;
    logic [0:0]    state_q;

    logic [DW-1:0] threshold_q;
    logic          thr_valid_q;
    logic          primed_q;
    logic          peak_q;

    logic [SW-1:0] sum_next;
    logic [SW-1:0] avg_next;
    logic [DW-1:0] thr_next;
    logic [PW-1:0] wptr_next;

    // Saturating magnitude: the most negative input cannot be negated in DW bits.
    always_comb begin
        mag = bus.in_data;
        if (bus.in_data == MOST_NEG) begin
            mag = MAG_MAX;
        end else if (bus.in_data[DW-1]) begin
            mag = '0 - bus.in_data;
        end
    end

    assign accept   = bus.in_valid & ~bus.clear;
    assign win_last = accept && (wcnt_q == CW'(WIN_LEN - 1));

    // Next ring sum, threshold and write pointer for a pending push.
    always_comb begin
        sum_next  = sum_q + SW'(win_max_q) - SW'(ring_q[wptr_q]);
        avg_next  = sum_next >> LW;
        thr_next  = DW'(avg_next >> THR_SHIFT);
        wptr_next = (wptr_q == PW'(NWIN - 1)) ? '0 : wptr_q + 1'b1;
    end

    // Window counter, running maximum and capture of the finished window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            cur_max_q <= '0;
            win_max_q <= '0;
            push_q    <= 1'b0;
        end else begin
            push_q <= win_last;
            if (bus.clear) begin
                wcnt_q    <= '0;
                cur_max_q <= '0;
            end else if (accept) begin
                if (wcnt_q == '0) begin
                    cur_max_q <= mag;
                end else if (mag > cur_max_q) begin
                    cur_max_q <= mag;
                end
                if (win_last) begin
                    win_max_q <= (mag > cur_max_q) ? mag : cur_max_q;
                    wcnt_q    <= '0;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
        end
    end

    // History ring, running sum, threshold and the FILL/RUN state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NWIN; i++) begin
                ring_q[i] <= '0;
            end
            sum_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            state_q     <= ST_FILL;
            threshold_q <= '0;
            thr_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            thr_valid_q <= push_q;
            if (push_q) begin
                sum_q          <= sum_next;
                ring_q[wptr_q] <= win_max_q;
                wptr_q         <= wptr_next;
                threshold_q    <= thr_next;
                case (state_q)
                    ST_FILL: begin
                        if (fill_q == FW'(NWIN - 1)) begin
                            state_q  <= ST_RUN;
                            primed_q <= 1'b1;
                        end else begin
                            fill_q <= fill_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // Peak flag compares against the threshold visible in the accept cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= 1'b0;
        end else begin
            peak_q <= accept & primed_q & (mag > threshold_q);
        end
    end

    assign bus.threshold = threshold_q;
    assign bus.thr_valid = thr_valid_q;
    assign bus.cur_max   = cur_max_q;
    assign bus.peak_flag = peak_q;
    assign bus.primed    = primed_q;
    assign bus.fsm_state = state_q[0];
endmodule

// File: tb/tb_ecg_peak_threshold.sv
// Bench for ecg_peak_threshold: directed windows followed by random traffic,
// checked every cycle against a window/history reference model.
module tb_ecg_peak_threshold;
    localparam int DW        = 16;
    localparam int WIN_LEN   = 4;
    localparam int NWIN      = 2;
    localparam int THR_SHIFT = 1;
    localparam int MAG_SAT   = (1 << (DW - 1)) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ecg_peak_threshold_if #(.DW(DW)) bus ();

    ecg_peak_threshold #(
        .DW(DW), .WIN_LEN(WIN_LEN), .NWIN(NWIN), .THR_SHIFT(THR_SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_win[$];    // magnitudes accepted in the open window
    int              m_hist[$];   // every completed window maximum
    int              m_cur_max;
    int              m_thr;
    bit              m_thr_valid;
    bit              m_primed;
    bit              m_peak;
    bit              m_pend;
    int              m_pend_max;
    logic [DW-1:0]   exp_q[$];    // thresholds awaiting a thr_valid pulse

    function automatic int mag_of(input logic [DW-1:0] d);
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        if (v > MAG_SAT) v = MAG_SAT;
        return v;
    endfunction

    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit c, input bit r);
        bit acc;
        int mg;
        int s;
        if (!r) begin
            m_win.delete();
            m_hist.delete();
            exp_q.delete();
            m_cur_max = 0; m_thr = 0; m_thr_valid = 0;
            m_primed = 0; m_peak = 0; m_pend = 0; m_pend_max = 0;
            return;
        end
        acc = v && !c;
        mg  = mag_of(d);
        m_peak = acc && m_primed && (mg > m_thr);
        m_thr_valid = 0;
        if (m_pend) begin
            m_hist.push_back(m_pend_max);
            s = 0;
            for (int i = 0; i < NWIN; i++) begin
                if (m_hist.size() - 1 - i >= 0) s += m_hist[m_hist.size() - 1 - i];
            end
            m_thr = (s / NWIN) >> THR_SHIFT;
            m_thr_valid = 1;
            if (m_hist.size() >= NWIN) m_primed = 1;
            m_pend = 0;
            exp_q.push_back(m_thr[DW-1:0]);
        end
        if (c) begin
            m_win.delete();
            m_cur_max = 0;
        end else if (acc) begin
            m_win.push_back(mg);
            m_cur_max = 0;
            foreach (m_win[i]) if (m_win[i] > m_cur_max) m_cur_max = m_win[i];
            if (m_win.size() == WIN_LEN) begin
                m_pend     = 1;
                m_pend_max = m_cur_max;
                m_win.delete();
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit v, input logic [DW-1:0] d, input bit c, input bit r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        rst_n        = r;
        @(posedge clk);
        model_edge(v, d, c, r);
        #1;
        chk("threshold", 32'(bus.threshold), 32'(m_thr));
        chk("thr_valid", 32'(bus.thr_valid), 32'(m_thr_valid));
        chk("cur_max",   32'(bus.cur_max),   32'(m_cur_max));
        chk("peak_flag", 32'(bus.peak_flag), 32'(m_peak));
        chk("primed",    32'(bus.primed),    32'(m_primed));
        if (bus.thr_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_extra_pulse", 32'(exp_q.size()), 32'd1);
            else chk("sb_threshold", 32'(bus.threshold), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic feed(input int x);
        logic [DW-1:0] d;
        d = x[DW-1:0];
        step(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
        rst_n        = 1'b0;

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        idle();

        // basic windows
        feed(3); feed(-10);
        chk("prime_peak_low", 32'(bus.peak_flag), 32'd0);
        feed(7); feed(2);
        idle();
        chk("w1_thr_valid", 32'(bus.thr_valid), 32'd1);
        chk("w1_thr", 32'(bus.threshold), 32'd2);
        chk("w1_primed", 32'(bus.primed), 32'd0);
        feed(5); feed(20); feed(-1); feed(0);
        idle();
        chk("w2_thr", 32'(bus.threshold), 32'd7);
        chk("w2_primed", 32'(bus.primed), 32'd1);
        feed(4); feed(-3); feed(1); feed(0);
        idle();
        chk("w3_thr", 32'(bus.threshold), 32'd6);

        // peak flag with threshold 7
        do_reset();
        feed(3); feed(-10); feed(7); feed(2); idle();
        feed(5); feed(20); feed(-1); feed(0); idle();
        chk("pk_thr", 32'(bus.threshold), 32'd7);
        feed(8);  chk("pk_8",  32'(bus.peak_flag), 32'd1);
        feed(7);  chk("pk_7",  32'(bus.peak_flag), 32'd0);
        feed(-7); chk("pk_m7", 32'(bus.peak_flag), 32'd0);
        feed(-9); chk("pk_m9", 32'(bus.peak_flag), 32'd1);
        idle();   chk("pk_idle", 32'(bus.peak_flag), 32'd0);

        // saturation
        do_reset();
        feed(-32768);
        chk("sat_cur_max", 32'(bus.cur_max), 32'd32767);
        feed(1); feed(2); feed(3); idle();
        feed(32767); feed(0); feed(-32768); feed(0); idle();
        chk("sat_thr", 32'(bus.threshold), 32'd16383);

        // gaps between samples
        do_reset();
        feed(3); idle(); feed(-10); idle(); idle(); feed(7); idle(); feed(2);
        idle();
        chk("gap_thr", 32'(bus.threshold), 32'd2);

        // clear mid-window, clear with a valid sample
        feed(50); feed(60);
        step(1'b1, 16'd1000, 1'b1, 1'b1);
        chk("clr_cur_max", 32'(bus.cur_max), 32'd0);
        feed(1); feed(2); feed(3);
        chk("clr_thr_hold", 32'(bus.threshold), 32'd2);
        feed(4); idle();
        chk("clr_thr", 32'(bus.threshold), 32'd3);

        // reset in the cycle after a window end
        feed(100); feed(200); feed(300); feed(400);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("mp_thr", 32'(bus.threshold), 32'd0);
        chk("mp_valid", 32'(bus.thr_valid), 32'd0);
        idle(); idle();
        chk("mp_thr_after", 32'(bus.threshold), 32'd0);
        chk("mp_primed", 32'(bus.primed), 32'd0);
        feed(3); feed(-10); feed(7); feed(2); idle();
        chk("mp_w1_thr", 32'(bus.threshold), 32'd2);
        chk("mp_w1_primed", 32'(bus.primed), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int s;
            logic [DW-1:0] d;
            sel = $urandom_range(0, 19);
            if (sel == 0)      d = 16'h8000;
            else if (sel == 1) d = 16'h7fff;
            else begin
                s = int'($urandom_range(0, 600)) - 300;
                d = s[DW-1:0];
            end
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 399) != 0);
        end
        idle(); idle();

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
